matrix_mult_sequencer: RTL and testbench

Initiator-side controller that drives one inner-product engine over its row/column/out strobe-ack interface to compute C = A x B for N x N IEEE-754 single-precision matrices. It loads A and B word-serially from an upstream stream and issues each row-of-A / column-of-B pair to the engine. It collects the N*N scalar results and streams C out row-major. It sits between the host load/unload path and the inner-product datapath of the matrix multiplier top level.

---
 rtl/matrix_mult_sequencer.sv | 168 ++++++++++++++++
 tb/tb_matrix_mult_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mult_sequencer.sv
// matrix_mult_sequencer: loads A and B word-serially, drives an inner-product engine per (row, column) pair, streams C row-major.
module matrix_mult_sequencer #(
  parameter int N = 4,
  parameter int WORD = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [WORD-1:0] in_data,
  input  logic            in_stb,
  output logic            in_ack,
  output logic [WORD*N-1:0] ip_row,
  output logic            ip_row_stb,
  input  logic            ip_row_ack,
  output logic [WORD*N-1:0] ip_column,
  output logic            ip_column_stb,
  input  logic            ip_column_ack,
  input  logic [WORD-1:0] ip_out,
  input  logic            ip_out_stb,
  output logic            ip_out_ack,
  output logic [WORD-1:0] res_data,
  output logic            res_stb,
  input  logic            res_ack,
  output logic            busy
);
  localparam int NN = N * N;
  localparam int LW = $clog2(2 * NN);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(NN);
  typedef enum logic [2:0] {LOAD, ISSUE, WAIT, GAP, DRAIN} state_t;
  state_t state_q, state_d;
  logic [LW-1:0] load_cnt_q, load_cnt_d;
  logic [IW-1:0] i_q, i_d, j_q, j_d, ld_r, ld_c;
  logic [CW-1:0] idx_q, idx_d, nidx;
  logic row_seen_q, row_seen_d, col_seen_q, col_seen_d, prev_stb_q, prev_stb_d;
  logic [WORD*N-1:0] ip_row_q, ip_row_d, ip_column_q, ip_column_d;
  logic [WORD-1:0] res_data_q, res_data_d;
  logic in_ack_q, in_ack_d, stb_q, stb_d, ip_out_ack_q, ip_out_ack_d, res_stb_q, res_stb_d, busy_q, busy_d;
  logic ld_we, ld_b, c_we, row_done, col_done, last_j, last_i;
  logic [WORD-1:0] a_mem [N][N];
  logic [WORD-1:0] b_mem [N][N];
  logic [WORD-1:0] c_mem [N][N];
  assign ld_r = IW'((load_cnt_q / LW'(N)) % LW'(N));
  assign ld_c = IW'(load_cnt_q % LW'(N));
  assign ld_b = load_cnt_q >= LW'(NN);
  assign ld_we = state_q == LOAD && in_stb && in_ack_q;
  assign nidx = idx_q + CW'(1);
  assign row_done = row_seen_q | ip_row_ack;
  assign col_done = col_seen_q | ip_column_ack;
  // engine may leave ip_out_stb high between operations, so only a 0->1 edge is a new result
  assign c_we = state_q == WAIT && ip_out_stb && !prev_stb_q;
  assign last_j = j_q == IW'(N - 1);
  assign last_i = i_q == IW'(N - 1);
  always_comb begin
    state_d = state_q;
    load_cnt_d = load_cnt_q;
    i_d = i_q;
    j_d = j_q;
    idx_d = idx_q;
    row_seen_d = row_seen_q;
    col_seen_d = col_seen_q;
    prev_stb_d = ip_out_stb;
    ip_row_d = ip_row_q;
    ip_column_d = ip_column_q;
    res_data_d = res_data_q;
    case (state_q)
      LOAD: if (ld_we) begin
        load_cnt_d = load_cnt_q + LW'(1);
        if (load_cnt_q == LW'(2 * NN - 1)) begin
          state_d = ISSUE;
          load_cnt_d = '0;
          i_d = '0;
          j_d = '0;
        end
      end
      ISSUE: begin
        row_seen_d = row_done;
        col_seen_d = col_done;
        if (row_done && col_done) begin
          state_d = WAIT;
          row_seen_d = 1'b0;
          col_seen_d = 1'b0;
        end
      end
      WAIT: if (c_we) begin
        j_d = last_j ? '0 : j_q + IW'(1);
        i_d = last_j ? (last_i ? '0 : i_q + IW'(1)) : i_q;
        state_d = last_i && last_j ? DRAIN : GAP;
        if (last_i && last_j) begin
          idx_d = '0;
          res_data_d = c_mem[0][0];
        end
      end
      GAP: state_d = ISSUE;
      DRAIN: if (res_ack) begin
        idx_d = nidx;
        res_data_d = c_mem[IW'(nidx / CW'(N))][IW'(nidx % CW'(N))];
        if (idx_q == CW'(NN - 1)) begin
          state_d = LOAD;
          idx_d = '0;
          load_cnt_d = '0;
        end
      end
      default: state_d = LOAD;
    endcase
    // operand registers are loaded once on ISSUE entry so they hold while strobes are up
    if (state_d == ISSUE && state_q != ISSUE)
      for (int k = 0; k < N; k++) begin
        ip_row_d[WORD*k +: WORD] = a_mem[i_d][k];
        ip_column_d[WORD*k +: WORD] = b_mem[k][j_d];
      end
    in_ack_d = state_d == LOAD;
    stb_d = state_d == ISSUE;
    ip_out_ack_d = state_d == ISSUE || state_d == WAIT;
    res_stb_d = state_d == DRAIN;
    busy_d = state_d != LOAD;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
      load_cnt_q <= '0;
      i_q <= '0;
      j_q <= '0;
      idx_q <= '0;
      row_seen_q <= 1'b0;
      col_seen_q <= 1'b0;
      prev_stb_q <= 1'b0;
      ip_row_q <= '0;
      ip_column_q <= '0;
      res_data_q <= '0;
      in_ack_q <= 1'b1;
      stb_q <= 1'b0;
      ip_out_ack_q <= 1'b0;
      res_stb_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      load_cnt_q <= load_cnt_d;
      i_q <= i_d;
      j_q <= j_d;
      idx_q <= idx_d;
      row_seen_q <= row_seen_d;
      col_seen_q <= col_seen_d;
      prev_stb_q <= prev_stb_d;
      ip_row_q <= ip_row_d;
      ip_column_q <= ip_column_d;
      res_data_q <= res_data_d;
      in_ack_q <= in_ack_d;
      stb_q <= stb_d;
      ip_out_ack_q <= ip_out_ack_d;
      res_stb_q <= res_stb_d;
      busy_q <= busy_d;
    end
  end
  always_ff @(posedge clk) begin
    if (ld_we && !ld_b) a_mem[ld_r][ld_c] <= in_data;
    if (ld_we && ld_b) b_mem[ld_r][ld_c] <= in_data;
    if (c_we) c_mem[i_q][j_q] <= ip_out;
  end
  assign in_ack = in_ack_q;
  assign ip_row = ip_row_q;
  assign ip_column = ip_column_q;
  assign ip_row_stb = stb_q;
  assign ip_column_stb = stb_q;
  assign ip_out_ack = ip_out_ack_q;
  assign res_data = res_data_q;
  assign res_stb = res_stb_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_matrix_mult_sequencer.sv
// tb_matrix_mult_sequencer: directed bench for matrix_mult_sequencer with N=2 and a table-driven engine.
module tb_matrix_mult_sequencer;
  localparam int N = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] in_data = '0;
  logic in_stb = 1'b0;
  logic in_ack;
  logic [63:0] ip_row, ip_column;
  logic ip_row_stb, ip_column_stb;
  logic ip_row_ack = 1'b0;
  logic ip_column_ack = 1'b0;
  logic [31:0] ip_out = '0;
  logic ip_out_stb = 1'b0;
  logic ip_out_ack;
  logic [31:0] res_data;
  logic res_stb;
  logic res_ack = 1'b0;
  logic busy;
  int nvec = 0;
  int nerr = 0;
  logic [31:0] wa [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  logic [31:0] wb [4] = '{32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
  logic [31:0] wc [4] = '{32'h41980000, 32'h41B00000, 32'h422C0000, 32'h42480000};

  matrix_mult_sequencer #(.N(N), .WORD(32)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_stb(in_stb), .in_ack(in_ack),
    .ip_row(ip_row), .ip_row_stb(ip_row_stb), .ip_row_ack(ip_row_ack),
    .ip_column(ip_column), .ip_column_stb(ip_column_stb), .ip_column_ack(ip_column_ack),
    .ip_out(ip_out), .ip_out_stb(ip_out_stb), .ip_out_ack(ip_out_ack),
    .res_data(res_data), .res_stb(res_stb), .res_ack(res_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input bit toggle);
    for (int w = 0; w < 8; w++) begin
      if (toggle) begin
        in_stb = 1'b0;
        in_data = 32'hBAD00000 | w;
        @(negedge clk);
      end
      in_stb = 1'b1;
      in_data = w < 4 ? wa[w] : wb[w-4];
      chk("load_in_ack", {63'd0, in_ack}, 64'd1);
      @(negedge clk);
    end
    in_stb = 1'b0;
    chk("load_done_in_ack", {63'd0, in_ack}, 64'd0);
    chk("load_done_busy", {63'd0, busy}, 64'd1);
  endtask

  task automatic serve(input int p, input int rd, input int cd, input bit hold, input bit glitch);
    int t, mx, ri, cj;
    logic [63:0] r, c;
    t = 0;
    while (!ip_row_stb && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("issue_wait", {63'd0, ip_row_stb}, 64'd1);
    r = ip_row;
    c = ip_column;
    ri = -1;
    cj = -1;
    for (int i = 0; i < N; i++) begin
      if (r == {wa[2*i+1], wa[2*i]}) ri = i;
      if (c == {wb[2+i], wb[i]}) cj = i;
    end
    chk("pair_row", 64'(ri), 64'(p / 2));
    chk("pair_col", 64'(cj), 64'(p % 2));
    chk("issue_in_ack", {63'd0, in_ack}, 64'd0);
    mx = rd > cd ? rd : cd;
    for (t = 0; t <= mx; t++) begin
      ip_row_ack = t == rd;
      ip_column_ack = t == cd;
      if (glitch) begin
        ip_out_stb = t == 0;
        ip_out = 32'hDEADBEEF;
      end
      chk("issue_strobes", {62'd0, ip_row_stb, ip_column_stb}, 64'd3);
      chk("issue_row_stable", ip_row, r);
      @(negedge clk);
    end
    ip_row_ack = 1'b0;
    ip_column_ack = 1'b0;
    if (glitch) ip_out_stb = 1'b0;
    chk("wait_strobes", {62'd0, ip_row_stb, ip_column_stb}, 64'd0);
    chk("wait_out_ack", {63'd0, ip_out_ack}, 64'd1);
    @(negedge clk);
    if (ip_out_stb) begin
      ip_out_stb = 1'b0;
      @(negedge clk);
    end
    ip_out = (ri < 0 || cj < 0) ? 32'hDEAD0000 : wc[2*ri+cj];
    ip_out_stb = 1'b1;
    @(negedge clk);
    if (!hold) ip_out_stb = 1'b0;
    chk("after_capture_out_ack", {63'd0, ip_out_ack}, 64'd0);
    chk("after_capture_stb", {63'd0, ip_row_stb}, 64'd0);
    if (p != 3) begin
      @(negedge clk);
      chk("gap_one_cycle", {63'd0, ip_row_stb}, 64'd1);
    end
  endtask

  task automatic drain(input int stall);
    logic [31:0] held;
    for (int k = 0; k < 4; k++) begin
      if (k == stall) begin
        res_ack = 1'b0;
        held = res_data;
        repeat (5) begin
          chk("stall_stb", {63'd0, res_stb}, 64'd1);
          chk("stall_data", {32'd0, res_data}, {32'd0, held});
          @(negedge clk);
        end
      end
      res_ack = 1'b1;
      chk("drain_stb", {63'd0, res_stb}, 64'd1);
      chk("drain_data", {32'd0, res_data}, {32'd0, wc[k]});
      chk("drain_busy", {63'd0, busy}, 64'd1);
      chk("drain_in_ack", {63'd0, in_ack}, 64'd0);
      @(negedge clk);
    end
    res_ack = 1'b0;
    chk("drain_end_stb", {63'd0, res_stb}, 64'd0);
    chk("drain_end_busy", {63'd0, busy}, 64'd0);
    chk("drain_end_in_ack", {63'd0, in_ack}, 64'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_row_stb", {63'd0, ip_row_stb}, 64'd0);
    chk("rst_res_stb", {63'd0, res_stb}, 64'd0);
    chk("rst_out_ack", {63'd0, ip_out_ack}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_row", ip_row, 64'd0);
    chk("rst_res_data", {32'd0, res_data}, 64'd0);
    rst = 1'b1;
    #1;
    chk("rel_in_ack", {63'd0, in_ack}, 64'd1);
    // run 1: plain load, mixed ack timing, row acked 3 cycles before column with a stray result pulse
    load(1'b0);
    chk("first_row", ip_row, 64'h40000000_3F800000);
    chk("first_col", ip_column, 64'h40E00000_40A00000);
    serve(0, 0, 0, 1'b0, 1'b0);
    serve(1, 0, 3, 1'b0, 1'b1);
    serve(2, 2, 1, 1'b0, 1'b0);
    serve(3, 1, 1, 1'b0, 1'b0);
    drain(-1);
    // run 2: half-rate load, engine holds ip_out_stb high, garbage in_stb while busy, stalled drain
    load(1'b1);
    in_stb = 1'b1;
    in_data = 32'hFFFFFFFF;
    serve(0, 1, 0, 1'b1, 1'b0);
    serve(1, 0, 0, 1'b1, 1'b0);
    serve(2, 3, 0, 1'b1, 1'b0);
    serve(3, 0, 2, 1'b1, 1'b0);
    in_stb = 1'b0;
    ip_out_stb = 1'b0;
    drain(1);
    // run 3: reset during WAIT, then full reload
    load(1'b0);
    ip_row_ack = 1'b1;
    ip_column_ack = 1'b1;
    @(negedge clk);
    ip_row_ack = 1'b0;
    ip_column_ack = 1'b0;
    chk("pre_rst_wait_out_ack", {63'd0, ip_out_ack}, 64'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_stb", {63'd0, ip_row_stb}, 64'd0);
    chk("mid_rst_out_ack", {63'd0, ip_out_ack}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_row", ip_row, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rel_in_ack", {63'd0, in_ack}, 64'd1);
    load(1'b0);
    serve(0, 0, 1, 1'b0, 1'b0);
    serve(1, 1, 0, 1'b0, 1'b0);
    serve(2, 0, 0, 1'b0, 1'b0);
    serve(3, 0, 0, 1'b0, 1'b0);
    drain(3);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
